// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/forward sequencer for the 5-stage pipeline with a data-memory wait FSM.
// Optional HAZ_PERF_CNT_EN adds StallCycles/FlushCount performance counters.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       ResultSrcE0,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       PCSrcE,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       Fault,
  output logic [1:0] dbg_state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  state_t             state, state_next;
  logic               pend_flush, pend_flush_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               lw_stall;

  // M stage holds the younger result, so it wins over W.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      pend_flush <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_next;
      pend_flush <= pend_flush_next;
      cnt        <= cnt_next;
    end
  end

  always_comb begin
    state_next      = state;
    pend_flush_next = pend_flush;
    cnt_next        = cnt;
    case (state)
      RUN: begin
        pend_flush_next = 1'b0;
        cnt_next        = '0;
        if (MemReqM && !MemReadyM) begin
          state_next = MEM_WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        // A branch resolved while frozen is replayed as a flush on return to RUN.
        if (PCSrcE) pend_flush_next = 1'b1;
        if (MemReadyM) begin
          state_next = RUN;
        end else if (cnt == CNT_W'(MEM_TIMEOUT)) begin
          state_next = FAULT;
        end else if (cnt != '1) begin
          cnt_next = cnt + 1'b1;
        end
      end
      FAULT:   state_next = FAULT;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    Fault  = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          StallF = lw_stall;
          StallD = lw_stall;
          FlushE = lw_stall || PCSrcE || pend_flush;
          FlushD = PCSrcE || pend_flush;
        end
        MEM_WAIT: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
          FlushW = 1'b1;
        end
        FAULT: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
          FlushW = 1'b1;
          Fault  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state;

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (StallD) StallCycles <= StallCycles + 32'd1;
      if (FlushE) FlushCount  <= FlushCount + 32'd1;
    end
  end
`endif

endmodule
